// File: rtl/pmem_arb_pkg.sv
// Shared types and constants for the pmem arbiter.
//   arb_state_e : arbiter FSM states
//   line_t      : default-width cache line (256 bits)
//   PRIO_RR / PRIO_FIXED : values for the PRIO_MODE parameter
//   idx_w()     : index width for an N-way select, never less than 1
package pmem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DONE
  } arb_state_e;

  localparam int DEF_LINE_W = 256;
  typedef logic [DEF_LINE_W-1:0] line_t;

  localparam logic PRIO_RR    = 1'b0;
  localparam logic PRIO_FIXED = 1'b1;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/pmem_arbiter_rr_picker.sv
// rr_picker: combinational N-way request picker.
//   req_i   : pending request vector
//   ptr_i   : round-robin start index (ignored in fixed mode)
//   fixed_i : 1 = lowest index wins, 0 = first pending at or after ptr_i
//   gnt_o   : one-hot grant
//   idx_o   : binary index of the grant
//   valid_o : at least one request pending
module rr_picker
  import pmem_arb_pkg::*;
#(
  parameter  int N  = 2,
  localparam int IW = idx_w(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  input  logic          fixed_i,
  output logic [N-1:0]  gnt_o,
  output logic [IW-1:0] idx_o,
  output logic          valid_o
);

  int start;
  int cand;

  // Scan the N candidates starting from the rotating base; the first pending
  // one wins. Fixed priority is the same scan with the base pinned at 0.
  always_comb begin
    // NOTE: every output gets a default before the loop so no path leaves a
    // value unassigned, which would otherwise infer a latch.
    gnt_o   = '0;
    idx_o   = '0;
    valid_o = 1'b0;
    cand    = 0;
    start   = fixed_i ? 0 : int'(ptr_i);
    for (int k = 0; k < N; k++) begin
      cand = (start + k) % N;
      if (!valid_o && req_i[cand]) begin
        valid_o     = 1'b1;
        gnt_o[cand] = 1'b1;
        idx_o       = IW'(cand);
      end
    end
  end

endmodule

// File: rtl/pmem_arbiter.sv
// pmem_arbiter: N-port arbiter in front of a single burst-memory port.
//   clk, rst            : clock, asynchronous active-low reset
//   req_read/req_write  : per-port line requests, held until req_resp
//   req_addr/req_wdata  : per-port line address and write line
//   req_resp            : one-cycle completion pulse to the granted port
//   req_rdata           : read line, valid while req_resp is high
//   pmem_read/pmem_write/pmem_addr/pmem_wdata : registered burst request
//   pmem_rdata/pmem_resp: burst memory return
//   busy, grant_id      : arbiter occupied / owning port
//   err_timeout         : sticky watchdog flag
module pmem_arbiter
  import pmem_arb_pkg::*;
#(
  parameter  int N_PORTS   = 2,
  parameter  int ADDR_W    = 32,
  parameter  int LINE_W    = 256,
  parameter  int PRIO_MODE = 0,
  parameter  int TIMEOUT   = 1024,
  localparam int GNT_W     = idx_w(N_PORTS)
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [N_PORTS-1:0]              req_read,
  input  logic [N_PORTS-1:0]              req_write,
  input  logic [N_PORTS-1:0][ADDR_W-1:0]  req_addr,
  input  logic [N_PORTS-1:0][LINE_W-1:0]  req_wdata,
  output logic [N_PORTS-1:0]              req_resp,
  output logic [LINE_W-1:0]               req_rdata,
  output logic                            pmem_read,
  output logic                            pmem_write,
  output logic [ADDR_W-1:0]               pmem_addr,
  output logic [LINE_W-1:0]               pmem_wdata,
  input  logic [LINE_W-1:0]               pmem_rdata,
  input  logic                            pmem_resp,
  output logic                            busy,
  output logic [GNT_W-1:0]                grant_id,
  output logic                            err_timeout
);

  localparam int               CNT_W    = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'((TIMEOUT > 0) ? TIMEOUT : 0);
  localparam logic [CNT_W-1:0] CNT_TRIP = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  arb_state_e           state_q;
  logic [GNT_W-1:0]     grant_q;
  logic [GNT_W-1:0]     ptr_q;
  logic [GNT_W-1:0]     ptr_d;
  logic [N_PORTS-1:0]   gnt_oh_q;
  logic [N_PORTS-1:0]   resp_q;
  logic [LINE_W-1:0]    rdata_q;
  logic                 pmem_read_q;
  logic                 pmem_write_q;
  logic [ADDR_W-1:0]    pmem_addr_q;
  logic [LINE_W-1:0]    pmem_wdata_q;
  logic [CNT_W-1:0]     wd_cnt_q;
  logic                 err_q;

  logic [N_PORTS-1:0]   pick_gnt;
  logic [GNT_W-1:0]     pick_idx;
  logic                 pick_valid;

  rr_picker #(
    .N (N_PORTS)
  ) u_picker (
    .req_i   (req_read | req_write),
    .ptr_i   (ptr_q),
    .fixed_i (PRIO_MODE == int'(PRIO_FIXED)),
    .gnt_o   (pick_gnt),
    .idx_o   (pick_idx),
    .valid_o (pick_valid)
  );

  // Pointer moves to the port after the winner so it has lowest precedence next.
  assign ptr_d = (pick_idx == GNT_W'(N_PORTS - 1)) ? '0 : pick_idx + 1'b1;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      grant_q      <= '0;
      ptr_q        <= '0;
      gnt_oh_q     <= '0;
      resp_q       <= '0;
      pmem_read_q  <= 1'b0;
      pmem_write_q <= 1'b0;
      pmem_addr_q  <= '0;
      // NOTE: the wide data registers are reset too because their
      // post-reset value is architecturally visible on the ports.
      pmem_wdata_q <= '0;
      rdata_q      <= '0;
      wd_cnt_q     <= '0;
      err_q        <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments throughout, so every register
      // samples pre-edge values regardless of statement order.
      case (state_q)
        IDLE: begin
          if (pick_valid) begin
            state_q      <= ISSUE;
            grant_q      <= pick_idx;
            gnt_oh_q     <= pick_gnt;
            ptr_q        <= ptr_d;
            pmem_addr_q  <= req_addr[pick_idx];
            pmem_wdata_q <= req_wdata[pick_idx];
            // A port raising both read and write is treated as a write.
            pmem_write_q <= req_write[pick_idx];
            pmem_read_q  <= ~req_write[pick_idx];
            wd_cnt_q     <= '0;
          end
        end
        ISSUE: begin
          if (wd_cnt_q != CNT_MAX) wd_cnt_q <= wd_cnt_q + 1'b1;
          // Flag on the edge that completes the TIMEOUT-th waiting cycle.
          if (TIMEOUT > 0 && wd_cnt_q == CNT_TRIP) err_q <= 1'b1;
          if (pmem_resp) begin
            rdata_q      <= pmem_rdata;
            pmem_read_q  <= 1'b0;
            pmem_write_q <= 1'b0;
            resp_q       <= gnt_oh_q;
            state_q      <= DONE;
          end
        end
        DONE: begin
          // No grant here: the requester needs this edge to drop its request.
          resp_q  <= '0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  always @(posedge clk) begin
    if (rst && state_q == IDLE) begin
      rw_conflict_a: assert (!(|(req_read & req_write)));
    end
  end

  assign req_resp    = resp_q;
  assign req_rdata   = rdata_q;
  assign pmem_read   = pmem_read_q;
  assign pmem_write  = pmem_write_q;
  assign pmem_addr   = pmem_addr_q;
  assign pmem_wdata  = pmem_wdata_q;
  assign busy        = (state_q != IDLE);
  assign grant_id    = grant_q;
  assign err_timeout = err_q;

endmodule

// File: tb/tb_pmem_arbiter.sv
module tb_pmem_arbiter;
  import pmem_arb_pkg::*;

  localparam int N  = 4;
  localparam int AW = 32;
  localparam int LW = 256;
  localparam int GW = 2;

  typedef struct {
    int               port;
    bit               wr;
    logic [AW-1:0]    addr;
    line_t            wdata;
  } txn_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // ---------------- instance A: round-robin, TIMEOUT=8 ----------------
  logic [N-1:0]         a_rd, a_wr, a_resp;
  logic [N-1:0][AW-1:0] a_addr;
  logic [N-1:0][LW-1:0] a_wdata;
  logic [LW-1:0]        a_rdata, a_pwdata, a_prdata;
  logic                 a_pread, a_pwrite, a_presp, a_busy, a_err;
  logic [AW-1:0]        a_paddr;
  logic [GW-1:0]        a_gnt;

  pmem_arbiter #(
    .N_PORTS(N), .ADDR_W(AW), .LINE_W(LW), .PRIO_MODE(int'(PRIO_RR)), .TIMEOUT(8)
  ) dut_a (
    .clk(clk), .rst(rst),
    .req_read(a_rd), .req_write(a_wr), .req_addr(a_addr), .req_wdata(a_wdata),
    .req_resp(a_resp), .req_rdata(a_rdata),
    .pmem_read(a_pread), .pmem_write(a_pwrite), .pmem_addr(a_paddr), .pmem_wdata(a_pwdata),
    .pmem_rdata(a_prdata), .pmem_resp(a_presp),
    .busy(a_busy), .grant_id(a_gnt), .err_timeout(a_err)
  );

  // ---------------- instance B: fixed priority, watchdog off ----------------
  logic [N-1:0]         b_rd, b_wr, b_resp;
  logic [N-1:0][AW-1:0] b_addr;
  logic [N-1:0][LW-1:0] b_wdata;
  logic [LW-1:0]        b_rdata, b_pwdata, b_prdata;
  logic                 b_pread, b_pwrite, b_presp, b_busy, b_err;
  logic [AW-1:0]        b_paddr;
  logic [GW-1:0]        b_gnt;

  pmem_arbiter #(
    .N_PORTS(N), .ADDR_W(AW), .LINE_W(LW), .PRIO_MODE(int'(PRIO_FIXED)), .TIMEOUT(0)
  ) dut_b (
    .clk(clk), .rst(rst),
    .req_read(b_rd), .req_write(b_wr), .req_addr(b_addr), .req_wdata(b_wdata),
    .req_resp(b_resp), .req_rdata(b_rdata),
    .pmem_read(b_pread), .pmem_write(b_pwrite), .pmem_addr(b_paddr), .pmem_wdata(b_pwdata),
    .pmem_rdata(b_prdata), .pmem_resp(b_presp),
    .busy(b_busy), .grant_id(b_gnt), .err_timeout(b_err)
  );

  // Requester / memory state shared with the stimulus tasks.
  txn_t          exp_q[$];
  int            b_exp[$];
  int            a_want[N], a_done[N], b_want[N], b_done[N];
  bit            a_op_wr[N];
  logic [AW-1:0] a_base[N];
  int            a_lat = 1;
  bit            a_hang = 1'b0;

  // Memory contents: a fixed pattern at 0x1000, address-derived elsewhere.
  function automatic line_t line_of(input logic [AW-1:0] addr);
    if (addr == 32'h0000_1000) return {32{8'hA5}};
    return {8{~addr}};
  endfunction

  function automatic line_t wdata_of(input int p);
    return {8{32'hC0DE_0000 | 32'(p)}};
  endfunction

  task automatic sync();
    @(negedge clk);
    #1;
  endtask

  task automatic start_a(input int p, input bit wr, input logic [AW-1:0] addr);
    txn_t t;
    t.port  = p;
    t.wr    = wr;
    t.addr  = addr;
    t.wdata = wr ? wdata_of(p) : '0;
    exp_q.push_back(t);
    a_op_wr[p] = wr;
    a_base[p]  = addr;
    a_want[p]++;
  endtask

  // Instance A: issue monitor + completion scoreboard, memory model, requesters.
  task automatic bfm_a();
    bit   prev   = 1'b0;
    int   wait_n = 0;
    txn_t t;
    forever begin
      @(negedge clk);
      if (!rst) begin
        a_rd = '0; a_wr = '0; a_presp = 1'b0; prev = 1'b0; wait_n = 0;
      end else begin
        if ((a_pread || a_pwrite) && !prev) begin
          checks++;
          if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL sb_issue unexpected burst grant=%0d addr=%h", a_gnt, a_paddr);
          end else begin
            t = exp_q[0];
            if (a_gnt !== GW'(t.port) || a_pwrite !== t.wr || a_pread !== !t.wr ||
                a_paddr !== t.addr || (t.wr && a_pwdata !== t.wdata)) begin
              failures++;
              $display("FAIL sb_issue got port=%0d rd=%0b wr=%0b addr=%h wdata=%h exp port=%0d wr=%0b addr=%h wdata=%h",
                       a_gnt, a_pread, a_pwrite, a_paddr, a_pwdata, t.port, t.wr, t.addr, t.wdata);
            end
          end
        end
        if (a_resp !== '0) begin
          checks++;
          if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL sb_resp unexpected resp=%b", a_resp);
          end else begin
            t = exp_q.pop_front();
            if (a_resp !== (N'(1) << t.port) || (!t.wr && a_rdata !== line_of(t.addr))) begin
              failures++;
              $display("FAIL sb_resp got resp=%b rdata=%h exp port=%0d rdata=%h",
                       a_resp, a_rdata, t.port, line_of(t.addr));
            end
          end
        end
        prev = a_pread || a_pwrite;

        a_presp = 1'b0;
        if (a_pread || a_pwrite) begin
          if (!a_hang) begin
            if (wait_n >= a_lat - 1) begin
              a_presp  = 1'b1;
              a_prdata = line_of(a_paddr);
              wait_n   = 0;
            end else begin
              wait_n++;
            end
          end
        end else begin
          wait_n = 0;
        end

        for (int p = 0; p < N; p++) begin
          if (a_resp[p]) begin
            a_rd[p] = 1'b0; a_wr[p] = 1'b0; a_done[p]++;
          end else if (!a_rd[p] && !a_wr[p] && a_want[p] > a_done[p]) begin
            a_addr[p]  = a_base[p];
            a_wdata[p] = wdata_of(p);
            if (a_op_wr[p]) a_wr[p] = 1'b1;
            else            a_rd[p] = 1'b1;
          end
        end
      end
    end
  endtask

  // Instance B: read-only requesters, 2-cycle memory, port-order scoreboard.
  task automatic bfm_b();
    int wait_n = 0;
    int ep;
    forever begin
      @(negedge clk);
      if (!rst) begin
        b_rd = '0; b_wr = '0; b_presp = 1'b0; wait_n = 0;
      end else begin
        if (b_resp !== '0) begin
          checks++;
          if (b_exp.size() == 0) begin
            failures++;
            $display("FAIL sb_fixed unexpected resp=%b", b_resp);
          end else begin
            ep = b_exp.pop_front();
            if (b_resp !== (N'(1) << ep) || b_rdata !== line_of(32'h7000 + 32'(ep * 64))) begin
              failures++;
              $display("FAIL sb_fixed got resp=%b rdata=%h exp port=%0d", b_resp, b_rdata, ep);
            end
          end
        end
        b_presp = 1'b0;
        if (b_pread || b_pwrite) begin
          if (wait_n >= 1) begin
            b_presp  = 1'b1;
            b_prdata = line_of(b_paddr);
            wait_n   = 0;
          end else begin
            wait_n++;
          end
        end else begin
          wait_n = 0;
        end
        for (int p = 0; p < N; p++) begin
          if (b_resp[p]) begin
            b_rd[p] = 1'b0; b_done[p]++;
          end else if (!b_rd[p] && b_want[p] > b_done[p]) begin
            b_addr[p] = 32'h7000 + 32'(p * 64);
            b_rd[p]   = 1'b1;
          end
        end
      end
    end
  endtask

  task automatic wait_strobe_a(input string name, input int budget);
    int n = 0;
    while (!(a_pread || a_pwrite) && n < budget) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (!(a_pread || a_pwrite)) begin
      failures++;
      $display("FAIL %s no pmem strobe within %0d cycles", name, budget);
    end
  endtask

  task automatic drain_a(input string name, input int budget);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL %s %0d transactions outstanding after %0d cycles", name, exp_q.size(), budget);
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    checks++;
    if ({a_pread, a_pwrite, a_busy, a_err, a_resp, a_gnt, a_paddr} !== '0) begin
      failures++;
      $display("FAIL reset_ctrl rd=%0b wr=%0b busy=%0b err=%0b resp=%b gnt=%0d addr=%h exp all 0",
               a_pread, a_pwrite, a_busy, a_err, a_resp, a_gnt, a_paddr);
    end
    checks++;
    if (a_pwdata !== '0 || a_rdata !== '0) begin
      failures++;
      $display("FAIL reset_data wdata=%h rdata=%h exp 0", a_pwdata, a_rdata);
    end
    checks++;
    if ({b_pread, b_busy, b_err, b_resp, b_gnt} !== '0) begin
      failures++;
      $display("FAIL reset_fixed rd=%0b busy=%0b err=%0b resp=%b gnt=%0d exp all 0",
               b_pread, b_busy, b_err, b_resp, b_gnt);
    end
    #1 rst = 1'b1;
  endtask

  task automatic test_single_read();
    int held = 1;
    int n    = 0;
    a_lat = 5;
    sync();
    start_a(1, 1'b0, 32'h0000_1000);
    @(negedge clk);
    checks++;
    if (a_pread !== 1'b0) begin
      failures++;
      $display("FAIL read_early pmem_read=%0b exp 0 in request cycle", a_pread);
    end
    @(negedge clk);
    checks++;
    if (a_pread !== 1'b1 || a_paddr !== 32'h0000_1000 || a_gnt !== 2'd1 || a_busy !== 1'b1) begin
      failures++;
      $display("FAIL read_issue rd=%0b addr=%h gnt=%0d busy=%0b exp 1/00001000/1/1",
               a_pread, a_paddr, a_gnt, a_busy);
    end
    while (a_pread && n < 20) begin
      @(negedge clk);
      n++;
      if (a_pread) held++;
    end
    checks++;
    if (held != 5) begin
      failures++;
      $display("FAIL read_hold pmem_read held %0d cycles exp 5", held);
    end
    checks++;
    if (a_resp !== 4'b0010 || a_rdata !== {32{8'hA5}}) begin
      failures++;
      $display("FAIL read_resp resp=%b rdata=%h exp 0010/a5..", a_resp, a_rdata);
    end
    @(negedge clk);
    checks++;
    if (a_resp !== 4'b0000 || a_busy !== 1'b0) begin
      failures++;
      $display("FAIL read_pulse resp=%b busy=%0b exp 0000/0 one cycle later", a_resp, a_busy);
    end
    drain_a("read_drain", 10);
  endtask

  task automatic test_reset_midburst();
    a_hang = 1'b1;
    sync();
    start_a(2, 1'b0, 32'h0000_2000);
    wait_strobe_a("midburst_issue", 10);
    #2 rst = 1'b0;
    #1;
    checks++;
    if ({a_pread, a_pwrite, a_busy, a_resp, a_gnt, a_paddr} !== '0) begin
      failures++;
      $display("FAIL reset_midburst rd=%0b wr=%0b busy=%0b resp=%b gnt=%0d addr=%h exp all 0",
               a_pread, a_pwrite, a_busy, a_resp, a_gnt, a_paddr);
    end
    exp_q.delete();
    for (int p = 0; p < N; p++) a_want[p] = a_done[p];
    a_hang = 1'b0;
    repeat (2) @(negedge clk);
    #1 rst = 1'b1;
  endtask

  // Pointer was left at 3 before the reset; a first grant to port 0 shows it
  // returned to 0, and the trailing port-0 grant shows the 3 -> 0 wrap.
  task automatic test_rr();
    a_lat = 1;
    sync();
    start_a(0, 1'b0, 32'h0000_3000);
    start_a(1, 1'b0, 32'h0000_3100);
    start_a(2, 1'b0, 32'h0000_3200);
    start_a(3, 1'b1, 32'h0000_3300);
    start_a(0, 1'b0, 32'h0000_3000);
    drain_a("rr_drain", 100);
  endtask

  task automatic test_write_hold();
    bit bad = 1'b0;
    int n   = 0;
    a_lat = 4;
    sync();
    start_a(0, 1'b1, 32'h0000_0040);
    wait_strobe_a("write_issue", 10);
    checks++;
    if (a_pwrite !== 1'b1 || a_pread !== 1'b0 || a_pwdata !== wdata_of(0)) begin
      failures++;
      $display("FAIL write_strobe wr=%0b rd=%0b wdata=%h exp 1/0/%h", a_pwrite, a_pread, a_pwdata, wdata_of(0));
    end
    sync();
    start_a(1, 1'b0, 32'h0000_0080);
    while (a_pwrite && n < 20) begin
      if (a_gnt !== 2'd0 || a_resp[1] !== 1'b0) bad = 1'b1;
      @(negedge clk);
      n++;
    end
    checks++;
    if (bad) begin
      failures++;
      $display("FAIL write_preempt port1 disturbed port0 burst gnt=%0d exp 0", a_gnt);
    end
    checks++;
    if (a_resp !== 4'b0001) begin
      failures++;
      $display("FAIL write_resp resp=%b exp 0001", a_resp);
    end
    @(negedge clk);
    checks++;
    if (a_busy !== 1'b0) begin
      failures++;
      $display("FAIL write_idle busy=%0b exp 0 after DONE", a_busy);
    end
    @(negedge clk);
    checks++;
    if (a_pread !== 1'b1 || a_gnt !== 2'd1) begin
      failures++;
      $display("FAIL write_next rd=%0b gnt=%0d exp 1/1", a_pread, a_gnt);
    end
    drain_a("write_drain", 20);
  endtask

  task automatic test_timeout();
    a_lat  = 1;
    a_hang = 1'b1;
    sync();
    start_a(3, 1'b0, 32'h0000_5000);
    wait_strobe_a("timeout_issue", 10);
    repeat (7) @(negedge clk);
    checks++;
    if (a_err !== 1'b0) begin
      failures++;
      $display("FAIL timeout_early err=%0b exp 0 after 7 ISSUE cycles", a_err);
    end
    @(negedge clk);
    checks++;
    if (a_err !== 1'b1) begin
      failures++;
      $display("FAIL timeout_set err=%0b exp 1 after 8 ISSUE cycles", a_err);
    end
    repeat (10) @(negedge clk);
    checks++;
    if (a_err !== 1'b1 || a_pread !== 1'b1 || a_busy !== 1'b1) begin
      failures++;
      $display("FAIL timeout_wait err=%0b rd=%0b busy=%0b exp 1/1/1", a_err, a_pread, a_busy);
    end
    #1 a_hang = 1'b0;
    drain_a("timeout_late_resp", 10);
    checks++;
    if (a_err !== 1'b1) begin
      failures++;
      $display("FAIL timeout_sticky err=%0b exp 1 after completion", a_err);
    end
    #1 rst = 1'b0;
    #1;
    checks++;
    if (a_err !== 1'b0) begin
      failures++;
      $display("FAIL timeout_clear err=%0b exp 0 in reset", a_err);
    end
    #3 rst = 1'b1;
  endtask

  task automatic test_fixed();
    int n = 0;
    sync();
    b_exp.push_back(0);
    b_exp.push_back(0);
    b_exp.push_back(0);
    b_exp.push_back(2);
    b_want[0] += 3;
    b_want[2] += 1;
    while (b_exp.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (b_exp.size() != 0) begin
      failures++;
      $display("FAIL fixed_drain %0d responses outstanding", b_exp.size());
    end
    repeat (2) @(negedge clk);
    checks++;
    if (b_err !== 1'b0 || b_busy !== 1'b0) begin
      failures++;
      $display("FAIL fixed_end err=%0b busy=%0b exp 0/0", b_err, b_busy);
    end
  endtask

  initial begin
    rst = 1'b1;
    a_rd = '0; a_wr = '0; a_addr = '0; a_wdata = '0; a_presp = 1'b0; a_prdata = '0;
    b_rd = '0; b_wr = '0; b_addr = '0; b_wdata = '0; b_presp = 1'b0; b_prdata = '0;
    fork
      bfm_a();
      bfm_b();
    join_none
    #2 rst = 1'b0;
    test_reset();
    test_single_read();
    test_reset_midburst();
    test_rr();
    test_write_hold();
    test_timeout();
    test_fixed();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
